// File: rtl/round_controller.sv
// rtl/round_controller.sv - door-game round sequencer: door generation, play countdown, judging, reveal
// Optional ROUND_PAUSE_EN adds a pause input that freezes PLAY and REVEAL.
module round_controller #(
    parameter int   PLAY_SECS   = 10,
    parameter int   REVEAL_SECS = 1,
    parameter int   INIT_LIVES  = 3,
    parameter int   NUM_DOORS   = 3,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick_1s,
    input  logic       start,
`ifdef ROUND_PAUSE_EN
    input  logic       pause,
`endif
    input  logic [1:0] p1_pos,
    input  logic [1:0] p2_pos,
    output logic [1:0] correct_door_1,
    output logic [1:0] correct_door_2,
    output logic [1:0] p1_lives,
    output logic [1:0] p2_lives,
    output logic [3:0] seconds_left,
    output logic       resume,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam logic [3:0] PLAY_LD   = PLAY_SECS[3:0];
    localparam logic [3:0] REVEAL_LD = REVEAL_SECS[3:0];
    localparam logic [1:0] LIVES_LD  = INIT_LIVES[1:0];
    localparam logic [2:0] ND        = NUM_DOORS[2:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLAY,
        S_JUDGE,
        S_REVEAL,
        S_OVER
    } state_t;

    state_t     state, state_next;
    logic [7:0] lfsr, lfsr_next;
    logic [1:0] door1, door1_next, door2, door2_next;
    logic [1:0] lives1, lives1_next, lives2, lives2_next;
    logic [3:0] secs, secs_next;
    logic [3:0] rev_cnt, rev_cnt_next;
    logic [1:0] pos1, pos1_next, pos2, pos2_next;
    logic       paused;

`ifdef ROUND_PAUSE_EN
    assign paused = pause;
`else
    assign paused = 1'b0;
`endif

    // Fold out-of-range 2-bit values back into 0..NUM_DOORS-1.
    function automatic logic [1:0] door_map(input logic [1:0] v);
        logic [2:0] w;
        w = {1'b0, v};
        if (w >= ND)
            w = w - ND;
        return w[1:0];
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            lfsr    <= LFSR_SEED;
            door1   <= 2'd0;
            door2   <= 2'd0;
            lives1  <= LIVES_LD;
            lives2  <= LIVES_LD;
            secs    <= PLAY_LD;
            rev_cnt <= 4'd0;
            pos1    <= 2'd0;
            pos2    <= 2'd0;
        end else begin
            state   <= state_next;
            lfsr    <= lfsr_next;
            door1   <= door1_next;
            door2   <= door2_next;
            lives1  <= lives1_next;
            lives2  <= lives2_next;
            secs    <= secs_next;
            rev_cnt <= rev_cnt_next;
            pos1    <= pos1_next;
            pos2    <= pos2_next;
        end
    end

    always_comb begin
        state_next   = state;
        lfsr_next    = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        door1_next   = door1;
        door2_next   = door2;
        lives1_next  = lives1;
        lives2_next  = lives2;
        secs_next    = secs;
        rev_cnt_next = rev_cnt;
        pos1_next    = pos1;
        pos2_next    = pos2;

        case (state)
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_next  = S_PLAY;
                    lives1_next = LIVES_LD;
                    lives2_next = LIVES_LD;
                    secs_next   = PLAY_LD;
                    door1_next  = door_map(lfsr[1:0]);
                    door2_next  = door_map(lfsr[3:2]);
                end
            end
            S_PLAY: begin
                if (tick_1s && !paused) begin
                    if (secs == 4'd1) begin
                        secs_next  = 4'd0;
                        pos1_next  = p1_pos;
                        pos2_next  = p2_pos;
                        state_next = S_JUDGE;
                    end else begin
                        secs_next = secs - 4'd1;
                    end
                end
            end
            S_JUDGE: begin
                if (pos1 != door1 && lives1 != 2'd0)
                    lives1_next = lives1 - 2'd1;
                if (pos2 != door2 && lives2 != 2'd0)
                    lives2_next = lives2 - 2'd1;
                rev_cnt_next = REVEAL_LD;
                state_next   = S_REVEAL;
            end
            S_REVEAL: begin
                if (tick_1s && !paused) begin
                    if (rev_cnt == 4'd1) begin
                        rev_cnt_next = 4'd0;
                        if (lives1 == 2'd0 || lives2 == 2'd0) begin
                            state_next = S_OVER;
                        end else begin
                            state_next = S_PLAY;
                            secs_next  = PLAY_LD;
                            door1_next = door_map(lfsr[1:0]);
                            door2_next = door_map(lfsr[3:2]);
                        end
                    end else begin
                        rev_cnt_next = rev_cnt - 4'd1;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign correct_door_1 = door1;
    assign correct_door_2 = door2;
    assign p1_lives       = lives1;
    assign p2_lives       = lives2;
    assign seconds_left   = secs;
    assign resume         = (state == S_REVEAL);
    assign game_over      = (state == S_OVER);

    always_comb begin
        winner = 2'b00;
        if (state == S_OVER)
            winner = {lives1 == 2'd0, lives2 == 2'd0};
    end

endmodule

// File: tb/tb_round_controller.sv
// tb/tb_round_controller.sv - directed self-checking bench for round_controller
module tb_round_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       tick_1s;
    logic       start;
`ifdef ROUND_PAUSE_EN
    logic       pause;
`endif
    logic [1:0] p1_pos, p2_pos;
    logic [1:0] cd1, cd2, l1, l2, winner;
    logic [3:0] secs;
    logic       resume, game_over;

    logic [1:0] cd1_n2, cd2_n2, cd1_n4, cd2_n4;
    logic [1:0] u_l1a, u_l2a, u_wa, u_l1b, u_l2b, u_wb;
    logic [3:0] u_sa, u_sb;
    logic       u_ra, u_ga, u_rb, u_gb;

    int checks   = 0;
    int failures = 0;
    int door_bad = 0;

    always #5 clk = ~clk;

    round_controller dut (
        .clk(clk), .reset_n(reset_n), .tick_1s(tick_1s), .start(start),
`ifdef ROUND_PAUSE_EN
        .pause(pause),
`endif
        .p1_pos(p1_pos), .p2_pos(p2_pos),
        .correct_door_1(cd1), .correct_door_2(cd2),
        .p1_lives(l1), .p2_lives(l2), .seconds_left(secs),
        .resume(resume), .game_over(game_over), .winner(winner)
    );

    round_controller #(.NUM_DOORS(2)) dut_n2 (
        .clk(clk), .reset_n(reset_n), .tick_1s(tick_1s), .start(start),
`ifdef ROUND_PAUSE_EN
        .pause(pause),
`endif
        .p1_pos(p1_pos), .p2_pos(p2_pos),
        .correct_door_1(cd1_n2), .correct_door_2(cd2_n2),
        .p1_lives(u_l1a), .p2_lives(u_l2a), .seconds_left(u_sa),
        .resume(u_ra), .game_over(u_ga), .winner(u_wa)
    );

    round_controller #(.NUM_DOORS(4)) dut_n4 (
        .clk(clk), .reset_n(reset_n), .tick_1s(tick_1s), .start(start),
`ifdef ROUND_PAUSE_EN
        .pause(pause),
`endif
        .p1_pos(p1_pos), .p2_pos(p2_pos),
        .correct_door_1(cd1_n4), .correct_door_2(cd2_n4),
        .p1_lives(u_l1b), .p2_lives(u_l2b), .seconds_left(u_sb),
        .resume(u_rb), .game_over(u_gb), .winner(u_wb)
    );

    always @(negedge clk) begin
        if (cd1 > 2'd2 || cd2 > 2'd2) door_bad++;
        if (cd1_n2 > 2'd1 || cd2_n2 > 2'd1) door_bad++;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_tick();
        @(negedge clk) tick_1s = 1'b1;
        @(negedge clk) tick_1s = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk) reset_n = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        @(negedge clk);
    endtask

    function automatic logic [1:0] wrong(input logic [1:0] d);
        return (d == 2'd2) ? 2'd0 : d + 2'd1;
    endfunction

    // Plays one full window, then one idle clock so JUDGE has completed.
    task automatic play_round(input bit p1_ok, input bit p2_ok);
        p1_pos = p1_ok ? cd1 : wrong(cd1);
        p2_pos = p2_ok ? cd2 : wrong(cd2);
        repeat (10) do_tick();
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0; tick_1s = 1'b0; start = 1'b0; p1_pos = 2'd0; p2_pos = 2'd0;
`ifdef ROUND_PAUSE_EN
        pause = 1'b0;
`endif
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        check("rst_l1", l1, 3);
        check("rst_l2", l2, 3);
        check("rst_secs", secs, 10);
        check("rst_resume", resume, 0);
        check("rst_over", game_over, 0);
        check("rst_winner", winner, 0);
        check("rst_doors", {cd1, cd2}, 0);
        do_tick();
        check("idle_tick_ignored", secs, 10);

        do_start();
        check("start_secs", secs, 10);
        p1_pos = cd1;
        p2_pos = wrong(cd2);
        repeat (9) do_tick();
        check("secs_at_1", secs, 1);
        do_tick();
        check("judge_secs0", secs, 0);
        check("judge_resume0", resume, 0);
        check("judge_l2_pre", l2, 3);
        @(negedge clk);
        check("r1_l1", l1, 3);
        check("r1_l2", l2, 2);
        check("r1_resume", resume, 1);
        do_tick();
        check("r1_resume_off", resume, 0);
        check("r1_secs_reload", secs, 10);

        do_reset();
        do_start();
        for (int r = 0; r < 3; r++) begin
            play_round(1'b0, 1'b0);
            check("both_l1", l1, 2 - r);
            check("both_l2", l2, 2 - r);
            do_tick();
        end
        check("both_over", game_over, 1);
        check("both_winner", winner, 3);
        check("both_resume", resume, 0);
        do_tick();
        check("over_lives_held", {l1, l2}, 0);

        do_start();
        check("restart_l1", l1, 3);
        check("restart_l2", l2, 3);
        check("restart_over", game_over, 0);
        check("restart_winner", winner, 0);
        for (int r = 0; r < 3; r++) begin
            play_round(1'b0, 1'b1);
            do_tick();
        end
        check("p1wrong_over", game_over, 1);
        check("p1wrong_winner", winner, 2);
        check("p1wrong_l2", l2, 3);
        check("p1wrong_l1", l1, 0);
        do_start();
        check("restart2_lives", {l1, l2}, 4'hF);
        check("restart2_over", game_over, 0);

        do_reset();
        @(negedge clk) begin start = 1'b1; tick_1s = 1'b1; end
        @(negedge clk) begin start = 1'b0; tick_1s = 1'b0; end
        check("start_tick_secs", secs, 10);
        repeat (6) do_tick();
        check("secs_at_4", secs, 4);
        @(negedge clk) reset_n = 1'b0;
        #1;
        check("async_rst_secs", secs, 10);
        check("async_rst_lives", {l1, l2}, 4'hF);
        @(negedge clk) reset_n = 1'b1;
        @(negedge clk);
        do_tick();
        check("after_rst_idle", secs, 10);

`ifdef ROUND_PAUSE_EN
        do_start();
        repeat (4) do_tick();
        check("pause_pre", secs, 6);
        pause = 1'b1;
        repeat (5) do_tick();
        check("pause_frozen", secs, 6);
        pause = 1'b0;
        do_tick();
        check("pause_release", secs, 5);
`endif

        check("door_range", door_bad, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    always @(posedge clk) begin
        if (reset_n) begin
            assert (cd1_n4 <= 2'd3 && cd2_n4 <= 2'd3);
        end
    end

endmodule
